// File: rtl/pulsegen_if.sv
// Trigger/pulse bundle for pulsegen: the trigger source drives in_trigger,
// and pulsegen drives the pulse line and its status flags.
interface pulsegen_if #(
   parameter int MAX_PENDING = 7
) ();
   localparam int PW = $clog2(MAX_PENDING + 1);

   logic          in_trigger;
   logic          out_signal;
   logic          out_busy;
   logic [PW-1:0] out_pending;
   logic          out_overflow;

   modport master (
      output in_trigger,
      input  out_signal,
      input  out_busy,
      input  out_pending,
      input  out_overflow
   );

   modport slave (
      input  in_trigger,
      output out_signal,
      output out_busy,
      output out_pending,
      output out_overflow
   );
endinterface

// File: rtl/pulsegen.sv
// Pulse generator: each accepted trigger becomes a PULSE_LEN-cycle pulse followed
// by at least GAP_LEN inactive cycles; triggers seen while busy are queued.
module pulsegen #(
   parameter int PULSE_LEN   = 4,
   parameter int GAP_LEN     = 4,
   parameter int MAX_PENDING = 7,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic      in_clk,
   input  logic      in_rst,
   pulsegen_if.slave bus
);
   localparam int   MAX_LEN  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int   CW       = $clog2(MAX_LEN + 1);
   localparam int   PW       = $clog2(MAX_PENDING + 1);
   localparam logic IDLE_LVL = ACTIVE_HIGH ? 1'b0 : 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [PW-1:0] pend, pend_nx;
   logic          ovf, ovf_nx;
   logic          sig_q, busy_q;
   logic          last_gap;

   assign last_gap = (state == S_GAP) && (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      ovf_nx   = ovf;

      case (state)
         S_IDLE: begin
            if (bus.in_trigger) begin
               state_nx = S_PULSE;
               cnt_nx   = CW'(PULSE_LEN - 1);
            end
         end
         S_PULSE: begin
            if (cnt == '0) begin
               state_nx = S_GAP;
               cnt_nx   = CW'(GAP_LEN - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_GAP: begin
            if (cnt != '0) begin
               cnt_nx = cnt - CW'(1);
            end else if (bus.in_trigger || (pend != '0)) begin
               // A trigger here either cancels the dequeue or is consumed directly.
               state_nx = S_PULSE;
               cnt_nx   = CW'(PULSE_LEN - 1);
               if (!bus.in_trigger) pend_nx = pend - PW'(1);
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase

      if (bus.in_trigger && (state != S_IDLE) && !last_gap) begin
         if (pend == PW'(MAX_PENDING)) ovf_nx = 1'b1;
         else                          pend_nx = pend + PW'(1);
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         pend   <= '0;
         ovf    <= 1'b0;
         sig_q  <= IDLE_LVL;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         pend   <= pend_nx;
         ovf    <= ovf_nx;
         // Decoding from the next state keeps the line one clean edge per boundary.
         sig_q  <= (state_nx == S_PULSE) ? ~IDLE_LVL : IDLE_LVL;
         busy_q <= (state_nx != S_IDLE);
      end
   end

   assign bus.out_signal   = sig_q;
   assign bus.out_busy     = busy_q;
   assign bus.out_pending  = pend;
   assign bus.out_overflow = ovf;
endmodule

// File: tb/tb_pulsegen.sv
// Bench for pulsegen: one active-high and one active-low instance share stimulus
// and are compared each cycle against a pulse-schedule reference model.
module tb_pulsegen;
   localparam int P = 3;
   localparam int G = 2;
   localparam int M = 2;

   logic clk;
   logic rst;

   pulsegen_if #(.MAX_PENDING(M)) bus_h ();
   pulsegen_if #(.MAX_PENDING(M)) bus_l ();

   pulsegen #(.PULSE_LEN(P), .GAP_LEN(G), .MAX_PENDING(M), .ACTIVE_HIGH(1'b1)) u_dut_h (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus_h.slave)
   );

   pulsegen #(.PULSE_LEN(P), .GAP_LEN(G), .MAX_PENDING(M), .ACTIVE_HIGH(1'b0)) u_dut_l (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus_l.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: start cycle of every accepted pulse still relevant.
   int starts[$];
   int last_start = -1000;
   bit ovf_seen   = 1'b0;
   bit armed      = 1'b0;
   int t          = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, t, obs, exp);
      end
   endtask

   task automatic cyc(input logic trig, input logic r);
      int  exp_pend;
      bit  exp_sig, exp_busy, boundary;
      @(negedge clk);
      while (starts.size() > 0 && starts[0] + P + G - 1 < t) void'(starts.pop_front());
      exp_sig  = 1'b0;
      exp_busy = 1'b0;
      exp_pend = 0;
      boundary = 1'b0;
      foreach (starts[i]) begin
         if (t >= starts[i] && t <= starts[i] + P - 1)     exp_sig  = 1'b1;
         if (t >= starts[i] && t <= starts[i] + P + G - 1) exp_busy = 1'b1;
         if (starts[i] > t)                                exp_pend++;
         if (starts[i] == t + 1)                           boundary = 1'b1;
      end
      if (armed) begin
         check_val("signal_h", 32'(bus_h.out_signal),   32'(exp_sig));
         check_val("signal_l", 32'(bus_l.out_signal),   32'(!exp_sig));
         check_val("busy_h",   32'(bus_h.out_busy),     32'(exp_busy));
         check_val("busy_l",   32'(bus_l.out_busy),     32'(exp_busy));
         check_val("pend_h",   32'(bus_h.out_pending),  32'(exp_pend));
         check_val("pend_l",   32'(bus_l.out_pending),  32'(exp_pend));
         check_val("ovf_h",    32'(bus_h.out_overflow), 32'(ovf_seen));
         check_val("ovf_l",    32'(bus_l.out_overflow), 32'(ovf_seen));
      end
      bus_h.in_trigger = trig;
      bus_l.in_trigger = trig;
      rst              = r;
      if (r) begin
         starts.delete();
         last_start = -1000;
         ovf_seen   = 1'b0;
         armed      = 1'b1;
      end else if (trig && armed) begin
         if (!exp_busy) begin
            last_start = t + 1;
            starts.push_back(last_start);
         end else if (exp_pend < M || boundary) begin
            last_start = last_start + P + G;
            starts.push_back(last_start);
         end else begin
            ovf_seen = 1'b1;
         end
      end
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
   endtask

   // Plays triggers at the given relative cycles within a window of len cycles.
   task automatic play(input int mask, input int len);
      for (int i = 0; i < len; i++) cyc(mask[i], 1'b0);
   endtask

   initial begin
      int dens;
      rst              = 1'b1;
      bus_h.in_trigger = 1'b0;
      bus_l.in_trigger = 1'b0;

      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      idle(6);

      play(32'b1, 10);               // single trigger
      play(32'b101, 14);             // triggers at 0 and 2
      play(32'b100101, 18);          // 0, 2 and last-gap cycle 5
      play(32'b1111, 20);            // overflow
      idle(4);
      cyc(1'b0, 1'b1);
      idle(3);
      play(32'b1, 2);                // reset during cycle 2 of a pulse
      cyc(1'b0, 1'b1);
      idle(6);

      for (int blk = 0; blk < 20; blk++) begin
         dens = $urandom_range(0, 100);
         for (int i = 0; i < 200; i++)
            cyc(($urandom_range(0, 99) < dens), ($urandom_range(0, 299) == 0));
      end
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
